aes_key_store: RTL and testbench

AES_KEY_STORE -- requirements
Module: aes_key_store

---
 rtl/aes_pkg.sv | 21 ++
 rtl/aes_byte_packer.sv | 38 +++
 rtl/aes_key_store.sv | 170 +++++++++++++++++
 tb/tb_aes_key_store.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared constants, FSM state type and byte-extraction helper for the AES round-key store.
package aes_pkg;

  localparam int NUM_ROUNDS      = 10;
  localparam int NUM_KEYS        = NUM_ROUNDS + 1;
  localparam int BYTES_PER_BLOCK = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_FULL = 2'd2
  } ks_state_e;

  // Byte idx of a 128-bit word, idx 0 being bits [127:120].
  function automatic logic [7:0] word_byte(input logic [127:0] word, input logic [3:0] idx);
    logic [127:0] w_shifted;
    w_shifted = word >> {4'd15 - idx, 3'd0};
    return w_shifted[7:0];
  endfunction

endpackage

// File: rtl/aes_byte_packer.sv
// Byte counter and MSB-first 128-bit assembly register; o_word_done pulses on the
// 16th accepted byte with o_word already including that byte.
import aes_pkg::*;

module aes_byte_packer (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clear,
  input  logic         i_byte_valid,
  input  logic [7:0]   i_byte,
  output logic [127:0] o_word,
  output logic         o_word_done
);

  logic [3:0]   r_cnt;
  logic [127:0] r_asm;

  // Shift accepted bytes in; the counter wraps to zero after the 16th byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 4'd0;
      r_asm <= 128'd0;
    end else if (i_clear) begin
      r_cnt <= 4'd0;
      r_asm <= 128'd0;
    end else if (i_byte_valid) begin
      r_cnt <= r_cnt + 4'd1;
      r_asm <= {r_asm[119:0], i_byte};
    end else begin
      r_cnt <= r_cnt;
      r_asm <= r_asm;
    end
  end

  assign o_word      = {r_asm[119:0], i_byte};
  assign o_word_done = i_byte_valid && (r_cnt == 4'(BYTES_PER_BLOCK - 1));

endmodule

// File: rtl/aes_key_store.sv
// Round-key store filled from a byte-serial key-expansion stream, one-cycle registered read.
// Optional byte-serial readout port enabled by defining AES_KEY_STORE_BYTE_OUT_EN.
import aes_pkg::*;

module aes_key_store #(
  parameter int NUM_KEYS = aes_pkg::NUM_KEYS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_key_start,
  input  logic [7:0]   i_key_byte,
  input  logic         i_key_byte_valid,
  input  logic [3:0]   i_rd_round,
  output logic [127:0] o_rd_key,
  output logic         o_rd_valid,
  output logic         o_keys_ready,
  output logic [3:0]   o_keys_stored,
`ifdef AES_KEY_STORE_BYTE_OUT_EN
  input  logic         i_bo_start,
  input  logic [3:0]   i_bo_round,
  output logic [7:0]   o_bo_byte,
  output logic         o_bo_valid,
`endif
  output logic         o_overflow
);

  ks_state_e    r_state;
  ks_state_e    w_state_nxt;
  logic         w_accept;
  logic         w_ovf_set;
  logic         w_word_done;
  logic [127:0] w_word;
  logic [3:0]   r_keys_stored;
  logic         r_overflow;
  logic [127:0] r_rd_key;
  logic         r_rd_valid;
  logic [127:0] r_store [NUM_KEYS];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; key_start restarts the fill from any state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: w_state_nxt = i_key_start ? ST_FILL : ST_IDLE;
      ST_FILL: begin
        if (i_key_start) begin
          w_state_nxt = ST_FILL;
        end else if (w_word_done && (r_keys_stored == 4'(NUM_KEYS - 1))) begin
          w_state_nxt = ST_FULL;
        end else begin
          w_state_nxt = ST_FILL;
        end
      end
      ST_FULL: w_state_nxt = i_key_start ? ST_FILL : ST_FULL;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Byte acceptance and overflow detection; a coincident key_start wins over the byte.
  always_comb begin
    w_accept  = 1'b0;
    w_ovf_set = 1'b0;
    if (!i_key_start && i_key_byte_valid) begin
      w_accept  = (r_state == ST_FILL);
      w_ovf_set = (r_state == ST_FULL);
    end else begin
      w_accept  = 1'b0;
      w_ovf_set = 1'b0;
    end
  end

  aes_byte_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (i_key_start),
    .i_byte_valid (w_accept),
    .i_byte       (i_key_byte),
    .o_word       (w_word),
    .o_word_done  (w_word_done)
  );

  // Store array; contents survive reset and key_start, visibility is governed by keys_stored.
  always_ff @(posedge clk) begin
    if (w_word_done) begin
      r_store[r_keys_stored] <= w_word;
    end
  end

  // Completed-key count and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst || i_key_start) begin
      r_keys_stored <= 4'd0;
      r_overflow    <= 1'b0;
    end else begin
      r_keys_stored <= w_word_done ? (r_keys_stored + 4'd1) : r_keys_stored;
      r_overflow    <= r_overflow | w_ovf_set;
    end
  end

  // Registered read; a key written this cycle is not yet counted, so it reads as invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_key   <= 128'd0;
      r_rd_valid <= 1'b0;
    end else if (i_rd_round < r_keys_stored) begin
      r_rd_key   <= r_store[i_rd_round];
      r_rd_valid <= 1'b1;
    end else begin
      r_rd_key   <= 128'd0;
      r_rd_valid <= 1'b0;
    end
  end

`ifdef AES_KEY_STORE_BYTE_OUT_EN
  logic [3:0] r_bo_round;
  logic [3:0] r_bo_idx;
  logic       r_bo_busy;
  logic [7:0] r_bo_byte;
  logic       r_bo_valid;

  // Byte-serial readout: first byte on the edge that sees bo_start, 15 more after it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bo_round <= 4'd0;
      r_bo_idx   <= 4'd0;
      r_bo_busy  <= 1'b0;
      r_bo_byte  <= 8'd0;
      r_bo_valid <= 1'b0;
    end else if (i_bo_start) begin
      r_bo_round <= i_bo_round;
      r_bo_idx   <= 4'd1;
      if (i_bo_round < r_keys_stored) begin
        r_bo_busy  <= 1'b1;
        r_bo_byte  <= word_byte(r_store[i_bo_round], 4'd0);
        r_bo_valid <= 1'b1;
      end else begin
        r_bo_busy  <= 1'b0;
        r_bo_byte  <= 8'd0;
        r_bo_valid <= 1'b0;
      end
    end else if (r_bo_busy) begin
      r_bo_idx   <= r_bo_idx + 4'd1;
      r_bo_busy  <= (r_bo_idx != 4'd15);
      r_bo_byte  <= word_byte(r_store[r_bo_round], r_bo_idx);
      r_bo_valid <= 1'b1;
    end else begin
      r_bo_byte  <= 8'd0;
      r_bo_valid <= 1'b0;
    end
  end

  assign o_bo_byte  = r_bo_byte;
  assign o_bo_valid = r_bo_valid;
`endif

  assign o_rd_key      = r_rd_key;
  assign o_rd_valid    = r_rd_valid;
  assign o_keys_ready  = (r_state == ST_FULL);
  assign o_keys_stored = r_keys_stored;
  assign o_overflow    = r_overflow;

endmodule

// File: tb/tb_aes_key_store.sv
// Directed self-checking bench for aes_key_store using the FIPS-197 AES-128 key expansion.
module tb_aes_key_store;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_key_start;
  logic [7:0]   i_key_byte;
  logic         i_key_byte_valid;
  logic [3:0]   i_rd_round;
  logic [127:0] o_rd_key;
  logic         o_rd_valid;
  logic         o_keys_ready;
  logic [3:0]   o_keys_stored;
  logic         o_overflow;
`ifdef AES_KEY_STORE_BYTE_OUT_EN
  logic         i_bo_start;
  logic [3:0]   i_bo_round;
  logic [7:0]   o_bo_byte;
  logic         o_bo_valid;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [127:0] exp_keys [11];
  int bytes_sent;

  always #5 clk = ~clk;

  aes_key_store dut (
    .clk              (clk),
    .rst              (rst),
    .i_key_start      (i_key_start),
    .i_key_byte       (i_key_byte),
    .i_key_byte_valid (i_key_byte_valid),
    .i_rd_round       (i_rd_round),
    .o_rd_key         (o_rd_key),
    .o_rd_valid       (o_rd_valid),
    .o_keys_ready     (o_keys_ready),
    .o_keys_stored    (o_keys_stored),
`ifdef AES_KEY_STORE_BYTE_OUT_EN
    .i_bo_start       (i_bo_start),
    .i_bo_round       (i_bo_round),
    .o_bo_byte        (o_bo_byte),
    .o_bo_valid       (o_bo_valid),
`endif
    .o_overflow       (o_overflow)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    i_key_start = 1'b1;
    tick();
    i_key_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_key_byte       = b;
    i_key_byte_valid = 1'b1;
    tick();
    i_key_byte_valid = 1'b0;
    i_key_byte       = 8'h00;
  endtask

  function automatic logic [7:0] key_byte_at(input int n);
    logic [127:0] w;
    w = exp_keys[n / 16];
    return w[127 - 8 * (n % 16) -: 8];
  endfunction

  task automatic read_check(input string tag, input logic [3:0] rnd,
                            input logic exp_v, input logic [127:0] exp_k);
    i_rd_round = rnd;
    tick();
    check({tag, "_valid"}, {127'd0, o_rd_valid}, {127'd0, exp_v});
    check({tag, "_key"}, o_rd_key, exp_k);
  endtask

  initial begin
    exp_keys[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    exp_keys[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    exp_keys[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    exp_keys[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    exp_keys[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    exp_keys[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    exp_keys[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    exp_keys[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    exp_keys[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    exp_keys[9]  = 128'hac7766f319fadc2128d12941575c006e;
    exp_keys[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    rst = 1'b1; i_key_start = 1'b0; i_key_byte = 8'h00; i_key_byte_valid = 1'b0;
    i_rd_round = 4'd0;
`ifdef AES_KEY_STORE_BYTE_OUT_EN
    i_bo_start = 1'b0; i_bo_round = 4'd0;
`endif
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_stored", {124'd0, o_keys_stored}, 128'd0);
    check("rst_ready", {127'd0, o_keys_ready}, 128'd0);
    check("rst_ovf", {127'd0, o_overflow}, 128'd0);
    check("rst_rd_valid", {127'd0, o_rd_valid}, 128'd0);
    check("rst_rd_key", o_rd_key, 128'd0);

    // Bytes in IDLE are ignored and do not set overflow
    send_byte(8'h55);
    check("idle_stored", {124'd0, o_keys_stored}, 128'd0);
    check("idle_ovf", {127'd0, o_overflow}, 128'd0);

    // Contiguous full stream
    pulse_start();
    for (int n = 0; n < 176; n++) begin
      i_key_byte = key_byte_at(n);
      i_key_byte_valid = 1'b1;
      tick();
    end
    i_key_byte_valid = 1'b0;
    check("full_stored", {124'd0, o_keys_stored}, 128'd11);
    check("full_ready", {127'd0, o_keys_ready}, 128'd1);
    for (int k = 0; k < 11; k++) read_check($sformatf("rd%0d", k), 4'(k), 1'b1, exp_keys[k]);
    read_check("rd15", 4'd15, 1'b0, 128'd0);
    read_check("rd11", 4'd11, 1'b0, 128'd0);

    // Extra byte in FULL sets overflow without disturbing the store
    send_byte(8'hee);
    check("ovf_set", {127'd0, o_overflow}, 128'd1);
    check("ovf_stored", {124'd0, o_keys_stored}, 128'd11);
    read_check("ovf_rd0", 4'd0, 1'b1, exp_keys[0]);
    check("ovf_sticky", {127'd0, o_overflow}, 128'd1);

`ifdef AES_KEY_STORE_BYTE_OUT_EN
    i_bo_round = 4'd1;
    i_bo_start = 1'b1;
    tick();
    i_bo_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("bo_valid%0d", i), {127'd0, o_bo_valid}, 128'd1);
      check($sformatf("bo_byte%0d", i), {120'd0, o_bo_byte}, {120'd0, key_byte_at(16 + i)});
      tick();
    end
    check("bo_end", {127'd0, o_bo_valid}, 128'd0);
`endif

    // key_start clears counters and hides contents
    pulse_start();
    check("ks_ovf", {127'd0, o_overflow}, 128'd0);
    check("ks_stored", {124'd0, o_keys_stored}, 128'd0);
    check("ks_ready", {127'd0, o_keys_ready}, 128'd0);
    read_check("ks_rd0", 4'd0, 1'b0, 128'd0);

    // Same stream with gaps; key 2 invisible until the cycle after its 48th byte
    bytes_sent = 0;
    while (bytes_sent < 176) begin
      if (bytes_sent == 47) begin
        check("gap_stored47", {124'd0, o_keys_stored}, 128'd2);
        i_rd_round = 4'd2;
        i_key_byte = key_byte_at(47);
        i_key_byte_valid = 1'b1;
        tick();
        i_key_byte_valid = 1'b0;
        check("gap_rd2_same", {127'd0, o_rd_valid}, 128'd0);
        tick();
        check("gap_rd2_next", {127'd0, o_rd_valid}, 128'd1);
        check("gap_rd2_key", o_rd_key, exp_keys[2]);
        bytes_sent++;
      end else begin
        repeat ((bytes_sent * 7 + 3) % 3) tick();
        send_byte(key_byte_at(bytes_sent));
        bytes_sent++;
      end
    end
    check("gap_stored", {124'd0, o_keys_stored}, 128'd11);
    check("gap_ready", {127'd0, o_keys_ready}, 128'd1);
    for (int k = 0; k < 11; k++) read_check($sformatf("gap_rd%0d", k), 4'(k), 1'b1, exp_keys[k]);

    // Reset mid-fill abandons the partial key
    pulse_start();
    for (int n = 0; n < 20; n++) send_byte(key_byte_at(48 + n));
    check("pre_rst_stored", {124'd0, o_keys_stored}, 128'd1);
    rst = 1'b1;
    i_key_start = 1'b1;
    tick();
    rst = 1'b0;
    i_key_start = 1'b0;
    check("mid_rst_stored", {124'd0, o_keys_stored}, 128'd0);
    check("mid_rst_ready", {127'd0, o_keys_ready}, 128'd0);
    send_byte(8'h11);
    check("mid_rst_idle", {124'd0, o_keys_stored}, 128'd0);
    pulse_start();
    for (int n = 0; n < 15; n++) send_byte(key_byte_at(48 + n));
    check("rst_15_bytes", {124'd0, o_keys_stored}, 128'd0);
    send_byte(key_byte_at(63));
    check("rst_16_bytes", {124'd0, o_keys_stored}, 128'd1);
    read_check("rst_rd0", 4'd0, 1'b1, exp_keys[3]);
    read_check("rst_rd15", 4'd15, 1'b0, 128'd0);

    // Partial key, then key_start with a coincident byte that must be discarded
    for (int n = 0; n < 5; n++) send_byte(8'h77);
    i_key_start = 1'b1;
    i_key_byte = 8'hAA;
    i_key_byte_valid = 1'b1;
    tick();
    i_key_start = 1'b0;
    i_key_byte_valid = 1'b0;
    check("aa_stored", {124'd0, o_keys_stored}, 128'd0);
    for (int n = 0; n < 16; n++) send_byte(key_byte_at(80 + n));
    check("aa_stored1", {124'd0, o_keys_stored}, 128'd1);
    read_check("aa_rd0", 4'd0, 1'b1, exp_keys[5]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
